// File: rtl/priority_dispatch_if.sv
// Handshake/bus bundle between the priority encoder side and priority_dispatch.
// The dispatcher takes the slave view; the driving side takes the master view.
interface priority_dispatch_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [7:0]       code_in;
    logic             out_ready;
    logic             err_clr;
    logic             out_valid;
    logic [3:0]       out_idx;
    logic [15:0]      clr_onehot;
    logic [CNT_W-1:0] grant_cnt;
    logic             err_illegal;
    logic             timeout_flag;

    modport master (
        output en, code_in, out_ready, err_clr,
        input  out_valid, out_idx, clr_onehot, grant_cnt, err_illegal, timeout_flag
    );

    modport slave (
        input  en, code_in, out_ready, err_clr,
        output out_valid, out_idx, clr_onehot, grant_cnt, err_illegal, timeout_flag
    );
endinterface

// File: rtl/priority_dispatch.sv
// Latches a priority-encoder index, offers it on valid/ready and pulses a one-hot clear per grant.
// Optional OFFER abandon timer is built when PRIO_DISPATCH_TIMEOUT_EN is defined.
module priority_dispatch #(
    parameter int HOLDOFF_CYCLES = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    priority_dispatch_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OFFER   = 2'd1,
        S_HOLDOFF = 2'd2
    } state_t;

    localparam int            HW        = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HW-1:0]    r_hold_cnt;
    logic [HW-1:0]    w_hold_nxt;
    logic             r_valid;
    logic [3:0]       r_idx;
    logic [15:0]      r_clr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_accept;
    logic             w_illegal;
    logic             w_hs;
    logic             w_tout;

`ifdef PRIO_DISPATCH_TIMEOUT_EN
    localparam int            TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abandon on the edge that closes the TIMEOUT_CYCLES-th unanswered OFFER cycle.
    localparam logic [TW-1:0] TLIM = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    logic [TW-1:0] r_wait;
    logic          r_tout;

    assign w_tout = (r_state == S_OFFER) && !w_hs && (r_wait >= TLIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
            r_tout <= 1'b0;
        end else begin
            if (r_state == S_OFFER && !w_hs && !w_tout)
                r_wait <= r_wait + TW'(1);
            else
                r_wait <= '0;
            if (bus.err_clr)
                r_tout <= 1'b0;
            else if (w_tout)
                r_tout <= 1'b1;
        end
    end

    assign bus.timeout_flag = r_tout;
`else
    assign w_tout           = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && bus.en && (bus.code_in[7:4] == 4'h0);
    assign w_illegal = (r_state == S_IDLE) && bus.en && (bus.code_in[7:4] != 4'h0)
                       && (bus.code_in != 8'hF0);
    assign w_hs      = (r_state == S_OFFER) && r_valid && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = S_OFFER;
            end
            S_OFFER: begin
                if (w_hs) begin
                    if (HOLDOFF_CYCLES > 0) begin
                        w_state_nxt = S_HOLDOFF;
                        w_hold_nxt  = HOLD_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_tout) begin
                    w_state_nxt = S_HOLDOFF;
                    w_hold_nxt  = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                // Leave when the count would reach zero, so HOLDOFF lasts exactly HOLDOFF_CYCLES.
                if (r_hold_cnt <= HW'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt - HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_valid    <= 1'b0;
            r_idx      <= 4'h0;
            r_clr      <= 16'h0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_idx   <= bus.code_in[3:0];
            end else if (w_hs || w_tout) begin
                r_valid <= 1'b0;
            end
            r_clr <= w_hs ? (16'h1 << r_idx) : 16'h0;
            if (w_hs && (r_cnt != {CNT_W{1'b1}}))
                r_cnt <= r_cnt + CNT_W'(1);
            if (bus.err_clr)
                r_err <= 1'b0;
            else if (w_illegal)
                r_err <= 1'b1;
        end
    end

    assign bus.out_valid   = r_valid;
    assign bus.out_idx     = r_idx;
    assign bus.clr_onehot  = r_clr;
    assign bus.grant_cnt   = r_cnt;
    assign bus.err_illegal = r_err;
endmodule
